// File: rtl/debug_pkg.sv
// Shared types and frame-format constants for the serial debug loader.
// A frame is SYNC, a word count N, then 4*N little-endian data bytes.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned DBG_MEM_DEPTH      = 32;
  localparam logic [7:0]  DBG_SYNC_BYTE      = 8'hA5;
  localparam int unsigned DBG_TIMEOUT_CYCLES = 1000000;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WCNT_W         = 6;

  // A count byte is usable only if it names between 1 and depth words.
  function automatic logic count_ok(input logic [7:0] cnt, input int unsigned depth);
    return (cnt != 8'd0) && (32'(cnt) <= depth);
  endfunction

endpackage

// File: rtl/debug_loader_if.sv
// Byte stream into the loader plus the instruction-memory write port it drives.
// master = byte source / memory side, slave = loader side.
interface debug_loader_if;
  import debug_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              DEBUG_SIG;
  logic [ADDR_W-1:0] DEBUG_addr;
  logic [WORD_W-1:0] DEBUG_instr;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  DEBUG_SIG,
    input  DEBUG_addr,
    input  DEBUG_instr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output DEBUG_SIG,
    output DEBUG_addr,
    output DEBUG_instr
  );

endinterface

// File: rtl/debug_timeout.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear, saturating at the limit.
// expired is a combinational decode of the count register; no backpressure.
module debug_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Loads framed bytes into instruction memory, one registered write strobe per assembled word.
// rx_ready is registered and drops during WRITE/DONE/ERROR; the core is held stalled while a frame loads.
module debug_loader
  import debug_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = DBG_MEM_DEPTH,
  parameter logic [7:0]  SYNC_BYTE      = DBG_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = DBG_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  debug_loader_if.slave     bus,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [WCNT_W-1:0] words_loaded
);

  state_t                state;
  logic [WCNT_W-1:0]     n_words;
  logic [WCNT_W-1:0]     word_idx;
  logic [LANE_IDX_W-1:0] byte_idx;
  logic [WORD_W-9:0]     lane_buf;
  logic                  rx_fire;
  logic                  to_en;
  logic                  to_expired;

  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign to_en   = (state == COUNT) || (state == DATA);

  debug_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_fire),
    .enable (to_en),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      n_words         <= '0;
      word_idx        <= '0;
      byte_idx        <= '0;
      lane_buf        <= '0;
      bus.rx_ready    <= 1'b0;
      bus.DEBUG_SIG   <= 1'b0;
      bus.DEBUG_addr  <= '0;
      bus.DEBUG_instr <= '0;
      core_hold       <= 1'b0;
      load_done       <= 1'b0;
      load_err        <= 1'b0;
      words_loaded    <= '0;
    end else begin
      bus.DEBUG_SIG <= 1'b0;
      load_done     <= 1'b0;

      unique case (state)
        IDLE: begin
          bus.rx_ready <= 1'b1;
          if (rx_fire && (bus.rx_data == SYNC_BYTE)) begin
            state        <= COUNT;
            core_hold    <= 1'b1;
            load_err     <= 1'b0;
            words_loaded <= '0;
          end
        end

        COUNT: begin
          if (rx_fire) begin
            if (count_ok(bus.rx_data, MEM_DEPTH)) begin
              n_words  <= WCNT_W'(bus.rx_data);
              word_idx <= '0;
              byte_idx <= '0;
              state    <= DATA;
            end else begin
              state        <= ERROR;
              bus.rx_ready <= 1'b0;
              load_err     <= 1'b1;
              core_hold    <= 1'b0;
            end
          end else if (to_expired) begin
            state        <= ERROR;
            bus.rx_ready <= 1'b0;
            load_err     <= 1'b1;
            core_hold    <= 1'b0;
          end
        end

        DATA: begin
          if (rx_fire) begin
            byte_idx <= byte_idx + LANE_IDX_W'(1);
            case (byte_idx)
              2'd0: lane_buf[7:0]   <= bus.rx_data;
              2'd1: lane_buf[15:8]  <= bus.rx_data;
              2'd2: lane_buf[23:16] <= bus.rx_data;
              default: begin
                // Last lane goes straight into the write port; address and data then hold until the next word.
                bus.DEBUG_SIG   <= 1'b1;
                bus.DEBUG_addr  <= ADDR_W'(word_idx);
                bus.DEBUG_instr <= {bus.rx_data, lane_buf};
                bus.rx_ready    <= 1'b0;
                state           <= WRITE;
              end
            endcase
          end else if (to_expired) begin
            state        <= ERROR;
            bus.rx_ready <= 1'b0;
            load_err     <= 1'b1;
            core_hold    <= 1'b0;
          end
        end

        WRITE: begin
          word_idx <= word_idx + WCNT_W'(1);
          if (words_loaded != WCNT_W'(MEM_DEPTH)) begin
            words_loaded <= words_loaded + WCNT_W'(1);
          end
          if ((word_idx + WCNT_W'(1)) == n_words) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            state        <= DATA;
            bus.rx_ready <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b1;
          core_hold    <= 1'b0;
        end

        ERROR: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b0;
          core_hold    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader: a frame-level model queues expected writes and frame outcomes.
module tb_debug_loader;
  import debug_pkg::*;

  localparam int unsigned DEPTH  = 32;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam int unsigned TO_CYC = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } wr_t;
  typedef struct {
    bit is_err;
    int words;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       core_hold;
  logic       load_done;
  logic       load_err;
  logic [5:0] words_loaded;

  debug_loader_if bus();

  int vectors = 0;
  int miscompares = 0;

  wr_t wr_q[$];
  ev_t ev_q[$];

  debug_loader #(
    .MEM_DEPTH(DEPTH),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference model: parse the frame as a whole and derive every write and the frame outcome.
  task automatic model_frame(input byte_q_t s, output bit exp_err, output int exp_words);
    int p = 0;
    int n;
    int full;
    while (p < s.size() && s[p] != SYNC) p++;
    n = int'(s[p+1]);
    if (n == 0 || n > int'(DEPTH)) begin
      exp_err = 1'b1;
      exp_words = 0;
    end else begin
      full = (s.size() - p - 2) / 4;
      if (full > n) full = n;
      for (int w = 0; w < full; w++) begin
        int b = p + 2 + 4 * w;
        wr_q.push_back('{32'(w), {s[b+3], s[b+2], s[b+1], s[b]}});
      end
      exp_err = (full != n);
      exp_words = full;
    end
    ev_q.push_back('{exp_err, exp_words});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      guard++;
      if (guard > 200) begin
        flag("rx_handshake", "rx_ready never rose within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t s, input bit stall);
    bit exp_err;
    int exp_words;
    int gap;
    model_frame(s, exp_err, exp_words);
    foreach (s[i]) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(s[i]);
    end
    if (stall) begin
      repeat (TO_CYC + 24) @(posedge clk);
      #1;
    end
    repeat (8) @(posedge clk);
    #1;
    check("writes_drained", wr_q.size(), 0);
    check("events_drained", ev_q.size(), 0);
    check("idle_words_loaded", words_loaded, exp_words);
    check("idle_load_err", load_err, exp_err);
    check("idle_core_hold", core_hold, 0);
    check("idle_rx_ready", bus.rx_ready, 1);
    wr_q.delete();
    ev_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_DEBUG_SIG"}, bus.DEBUG_SIG, 0);
    check({tag, "_DEBUG_addr"}, bus.DEBUG_addr, 0);
    check({tag, "_DEBUG_instr"}, bus.DEBUG_instr, 0);
    check({tag, "_core_hold"}, core_hold, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
    check({tag, "_rx_ready"}, bus.rx_ready, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic        prev_sig = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_instr = '0;

  initial begin : monitor
    wr_t w;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sig = 1'b0;
        prev_done = 1'b0;
        prev_err = 1'b0;
        continue;
      end
      if (prev_sig) begin
        check("strobe_one_cycle", bus.DEBUG_SIG, 0);
        check("addr_held", bus.DEBUG_addr, last_addr);
        check("instr_held", bus.DEBUG_instr, last_instr);
      end
      if (bus.DEBUG_SIG) begin
        if (wr_q.size() == 0) begin
          flag("unexpected_write", $sformatf("strobe addr %0h instr %0h with none expected",
                                             bus.DEBUG_addr, bus.DEBUG_instr));
        end else begin
          w = wr_q.pop_front();
          check("write_addr", bus.DEBUG_addr, w.addr);
          check("write_instr", bus.DEBUG_instr, w.instr);
        end
        check("write_core_hold", core_hold, 1);
        check("write_rx_ready", bus.rx_ready, 0);
        last_addr = bus.DEBUG_addr;
        last_instr = bus.DEBUG_instr;
      end
      if (prev_done) check("hold_release_after_done", core_hold, 0);
      if (load_done) begin
        if (ev_q.size() == 0) begin
          flag("unexpected_done", "load_done with no frame outcome expected");
        end else begin
          e = ev_q.pop_front();
          check("done_not_error", 0, 32'(e.is_err));
          check("done_words_loaded", words_loaded, 32'(e.words));
        end
        check("done_core_hold", core_hold, 1);
        check("done_rx_ready", bus.rx_ready, 0);
      end
      if (load_err && !prev_err) begin
        if (ev_q.size() == 0) begin
          flag("unexpected_error", "load_err rose with no frame outcome expected");
        end else begin
          e = ev_q.pop_front();
          check("error_expected", 1, 32'(e.is_err));
          check("error_words_loaded", words_loaded, 32'(e.words));
        end
        check("error_core_hold", core_hold, 0);
        check("error_rx_ready", bus.rx_ready, 0);
      end
      prev_sig = bus.DEBUG_SIG;
      prev_done = load_done;
      prev_err = load_err;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    byte_q_t s;
    int kind;
    int n;
    int nbytes;
    logic [7:0] junk;

    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("rx_ready_at_release", bus.rx_ready, 0);
    @(posedge clk);
    #1;
    check("rx_ready_first_clock", bus.rx_ready, 1);

    // Single word.
    s = {SYNC, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(s, 1'b0);

    // Full memory.
    s = {SYNC, 8'h20};
    repeat (128) s.push_back(8'($urandom));
    send_frame(s, 1'b0);

    // Reset after the second data byte of a frame.
    s = {SYNC, 8'h02, 8'h11, 8'h22};
    foreach (s[i]) send_byte(s[i]);
    check("hold_mid_frame", core_hold, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_frame_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rx_ready_after_mid_reset", bus.rx_ready, 1);
    s = {SYNC, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(s, 1'b0);

    // Count bounds.
    s = {SYNC, 8'h00};
    send_frame(s, 1'b0);
    s = {SYNC, 8'h21};
    send_frame(s, 1'b0);
    s = {SYNC, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s.delete();
    s = {SYNC, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(s, 1'b0);

    // Truncated frame then idle past the timeout.
    s = {SYNC, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(s, 1'b1);

    // Sync value inside the payload is data.
    s = {SYNC, 8'h01, SYNC, SYNC, SYNC, SYNC};
    send_frame(s, 1'b0);

    // Randomised frames with leading junk.
    for (int f = 0; f < 24; f++) begin
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h00;
        s.push_back(junk);
      end
      s.push_back(SYNC);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
        send_frame(s, 1'b0);
      end else if (kind == 1) begin
        n = $urandom_range(2, 8);
        s.push_back(8'(n));
        nbytes = $urandom_range(0, 4 * n - 1);
        repeat (nbytes) s.push_back(8'($urandom));
        send_frame(s, 1'b1);
      end else begin
        n = $urandom_range(1, DEPTH);
        s.push_back(8'(n));
        repeat (4 * n) s.push_back(8'($urandom));
        send_frame(s, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
